// File: rtl/bot_motion_sequencer_if.sv
// Command handshake and motion status bundle for the motion sequencer.
// Commands flow master -> slave on cmd_valid/cmd_ready; status flows back.
interface bot_motion_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_dir;
    logic [15:0] cmd_ticks;
    logic        abort;
    logic [2:0]  turn;
    logic        busy;
    logic        done;
    logic [2:0]  fifo_count;
    logic        err;

    modport master (
        output cmd_valid, cmd_dir, cmd_ticks, abort,
        input  cmd_ready, turn, busy, done, fifo_count, err
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_ticks, abort,
        output cmd_ready, turn, busy, done, fifo_count, err
    );
endinterface

// File: rtl/bot_motion_sequencer.sv
// Queued timed motion commands -> turn code, with stop dead-time between opposing turns.
// Push-to-turn latency 2 cycles from idle; cmd_ready drops when the 4-entry queue is full or abort is high.
module bot_motion_sequencer #(
    parameter int CLK_PER_TICK = 50000,
    parameter int DEAD_TICKS   = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk_50,
    input  logic                  reset,
    bot_motion_sequencer_if.slave bus
);
    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef struct packed {
        logic [2:0]  dir;
        logic [15:0] ticks;
    } cmd_t;

    state_t        state, state_n;
    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic [PW-1:0] presc;
    logic          tick, push, pop, full, empty;
    logic [2:0]    cur_dir, cur_dir_n, head_dir, prev_dir, turn_q;
    logic [15:0]   remaining, remaining_n;
    logic [DW-1:0] dead_cnt, dead_cnt_n;
    logic          done_n, err_set, try_load, need_dead, head_illegal;
    logic          busy_q, done_q, err_q;

    assign full          = (count == 3'(FIFO_DEPTH));
    assign empty         = (count == 3'd0);
    assign bus.cmd_ready = !full && !bus.abort;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = mem[rd_ptr];
    assign head_illegal  = (head.dir > 3'd4);
    assign head_dir      = head_illegal ? 3'd0 : head.dir;
    // Only a command handed over straight from RUN can need dead-time.
    assign prev_dir      = (state == RUN) ? cur_dir : 3'd0;
    assign need_dead     = (prev_dir != 3'd0) && (head_dir != 3'd0) && (prev_dir != head_dir);
    assign tick          = (presc == PW'(CLK_PER_TICK - 1));

    assign bus.turn       = turn_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fifo_count = count;
    assign bus.err        = err_q;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    always_comb begin
        state_n     = state;
        cur_dir_n   = cur_dir;
        remaining_n = remaining;
        dead_cnt_n  = dead_cnt;
        pop         = 1'b0;
        done_n      = 1'b0;
        err_set     = 1'b0;
        try_load    = 1'b0;
        case (state)
            IDLE: try_load = 1'b1;
            RUN: begin
                if (tick) begin
                    if (remaining == 16'd1) begin
                        done_n   = 1'b1;
                        try_load = 1'b1;
                        state_n  = IDLE;
                    end else if (remaining != 16'd0) begin
                        remaining_n = remaining - 16'd1;
                    end
                end
            end
            DEAD: begin
                if (dead_cnt == '0) begin
                    state_n = RUN;
                end else if (tick) begin
                    dead_cnt_n = dead_cnt - DW'(1);
                    if (dead_cnt == DW'(1)) state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        if (try_load && !empty) begin
            if (head.ticks == 16'd0) begin
                // Zero-length commands are retired from IDLE only, so done never merges two completions.
                if (state == IDLE) begin
                    pop    = 1'b1;
                    done_n = 1'b1;
                end
            end else begin
                pop         = 1'b1;
                cur_dir_n   = head_dir;
                remaining_n = head.ticks;
                dead_cnt_n  = DW'(DEAD_TICKS);
                err_set     = head_illegal;
                state_n     = need_dead ? DEAD : RUN;
            end
        end
        if (bus.abort) begin
            state_n = IDLE;
            pop     = 1'b0;
            done_n  = 1'b0;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_dir   <= 3'd0;
            remaining <= 16'd0;
            dead_cnt  <= '0;
            turn_q    <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cur_dir   <= cur_dir_n;
            remaining <= remaining_n;
            dead_cnt  <= dead_cnt_n;
            turn_q    <= (state_n == RUN) ? cur_dir_n : 3'd0;
            busy_q    <= (state_n != IDLE);
            done_q    <= done_n;
            err_q     <= err_q | err_set;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else if (bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (push) mem[wr_ptr] <= '{dir: bus.cmd_dir, ticks: bus.cmd_ticks};
    end
endmodule

// File: tb/tb_bot_motion_sequencer.sv
// Directed scenarios plus randomized command rounds checked against a tick-schedule model.
module tb_bot_motion_sequencer;
    localparam int CPT  = 4;
    localparam int DT   = 2;
    localparam int MAXC = 512;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;
    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   len, n;
    logic exp_err;

    logic [2:0] m_turn [MAXC];
    logic       m_busy [MAXC];
    logic       m_done [MAXC];
    int         pcyc [4];
    int         popc [4];
    logic [2:0] rdir [4];
    int         rtk  [4];

    bot_motion_sequencer_if bus();

    bot_motion_sequencer #(.CLK_PER_TICK(CPT), .DEAD_TICKS(DT), .FIFO_DEPTH(4)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    // Cycle index since reset release; the prescaler phase is cyc % CPT.
    always @(posedge clk_50 or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_50);
    endtask

    task automatic push(input logic [2:0] d, input logic [15:0] t);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        bus.cmd_ticks = t;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // n-th tick cycle at or after cycle s.
    function automatic int nth_tick(input int s, input int k);
        int f;
        f = s + (CPT - 1 - (s % CPT));
        return f + CPT * (k - 1);
    endfunction

    task automatic run_round(input bit fixed);
        int base, kp, p, rs, k, d, j, endc, idx, cnt;
        logic [2:0] ex, pv;
        base = cyc;
        for (int i = 0; i < MAXC; i++) begin
            m_turn[i] = 3'd0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (fixed) begin
                rdir[i] = (i == 0) ? 3'd2 : (i == 1) ? 3'd3 : 3'd1;
                rtk[i]  = 2;
                pcyc[i] = base + 1 + i;
            end else begin
                rdir[i] = 3'($urandom_range(0, 7));
                rtk[i]  = $urandom_range(1, 3);
                pcyc[i] = ((i == 0) ? base : pcyc[i-1]) + 1 + $urandom_range(0, 5);
            end
            if (rdir[i] > 3'd4) exp_err = 1'b1;
        end
        kp = -1;
        pv = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && pcyc[i] + 1 <= kp) begin
                p = kp;
            end else begin
                p  = (pcyc[i] + 1 > kp + 1) ? pcyc[i] + 1 : kp + 1;
                pv = 3'd0;
            end
            ex = (rdir[i] > 3'd4) ? 3'd0 : rdir[i];
            rs = p + 1;
            if (pv != 3'd0 && ex != 3'd0 && pv != ex) begin
                d = nth_tick(p + 1, DT);
                for (int c = p + 1; c <= d; c++) m_busy[c-base] = 1'b1;
                rs = d + 1;
            end
            k = nth_tick(rs, rtk[i]);
            for (int c = rs; c <= k; c++) begin
                m_turn[c-base] = ex;
                m_busy[c-base] = 1'b1;
            end
            m_done[k+1-base] = 1'b1;
            popc[i] = p;
            pv = ex;
            kp = k;
        end
        endc = kp + 3;
        j = 0;
        while (cyc <= endc) begin
            idx = cyc - base;
            cnt = 0;
            for (int i = 0; i < 4; i++)
                cnt = cnt + ((pcyc[i] + 1 <= cyc) ? 1 : 0) - ((popc[i] + 1 <= cyc) ? 1 : 0);
            chk("rnd_turn", bus.turn, m_turn[idx]);
            chk("rnd_busy", bus.busy, m_busy[idx]);
            chk("rnd_done", bus.done, m_done[idx]);
            chk("rnd_count", bus.fifo_count, cnt);
            if (j < 4 && cyc == pcyc[j]) begin
                chk("rnd_ready", bus.cmd_ready, 1);
                bus.cmd_valid = 1'b1;
                bus.cmd_dir   = rdir[j];
                bus.cmd_ticks = 16'(rtk[j]);
                j++;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            step();
        end
        bus.cmd_valid = 1'b0;
        chk("rnd_err", bus.err, exp_err);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 3'd0;
        bus.cmd_ticks = 16'd0;
        bus.abort     = 1'b0;
        exp_err       = 1'b0;

        #25;
        chk("rst_turn",  bus.turn, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_err",   bus.err, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        @(negedge clk_50);
        reset = 1'b0;

        // Single forward command pushed at cycle 10.
        while (cyc < 10) step();
        push(3'd1, 16'd3);
        chk("lat_count_n1", bus.fifo_count, 1);
        chk("lat_turn_n1", bus.turn, 0);
        step();
        chk("lat_turn_n2", bus.turn, 1);
        chk("lat_busy_n2", bus.busy, 1);
        len = 0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.turn == 3'd1) len++;
            step();
            n++;
        end
        chk("fwd_done", bus.done, 1);
        chk("fwd_done_cyc", cyc, 24);
        chk("fwd_run_len", len, 12);
        chk("fwd_end_turn", bus.turn, 0);
        chk("fwd_end_busy", bus.busy, 0);
        step();
        chk("fwd_done_width", bus.done, 0);

        // Zero-length extreme command from idle.
        push(3'd4, 16'd0);
        chk("zero_count_n1", bus.fifo_count, 1);
        step();
        chk("zero_done", bus.done, 1);
        chk("zero_turn", bus.turn, 0);
        chk("zero_busy", bus.busy, 0);
        chk("zero_count_n2", bus.fifo_count, 0);
        step();
        chk("zero_done_width", bus.done, 0);

        // Fill the queue behind a long command; a fifth offer must stall.
        push(3'd1, 16'd20);
        step();
        for (int i = 0; i < 4; i++) push(3'd2, 16'd1);
        chk("full_count", bus.fifo_count, 4);
        chk("full_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 3'd3;
        bus.cmd_ticks = 16'd1;
        repeat (3) step();
        chk("full_hold", bus.fifo_count, 4);
        chk("full_turn", bus.turn, 1);
        bus.cmd_valid = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("full_flush", bus.fifo_count, 0);

        // Abort mid-run with a command offered in the abort cycle.
        push(3'd1, 16'd5);
        push(3'd2, 16'd5);
        repeat (4) step();
        chk("abort_pre_turn", bus.turn, 1);
        chk("abort_pre_count", bus.fifo_count, 1);
        bus.abort     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 3'd3;
        bus.cmd_ticks = 16'd1;
        #1;
        chk("abort_ready", bus.cmd_ready, 0);
        step();
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("abort_turn", bus.turn, 0);
        chk("abort_count", bus.fifo_count, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (3) step();
        chk("abort_drop_count", bus.fifo_count, 0);
        chk("abort_drop_busy", bus.busy, 0);

        // Illegal direction runs as stop and sets the sticky error.
        push(3'd6, 16'd2);
        chk("ill_count", bus.fifo_count, 1);
        step();
        chk("ill_turn", bus.turn, 0);
        chk("ill_busy", bus.busy, 1);
        chk("ill_err", bus.err, 1);
        exp_err = 1'b1;
        len = 0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.turn != 3'd0) len++;
            step();
            n++;
        end
        chk("ill_done", bus.done, 1);
        chk("ill_nonstop_cycles", len, 0);
        repeat (2) step();
        chk("ill_err_sticky", bus.err, 1);

        // Reset while in dead-time with two commands queued.
        push(3'd2, 16'd1);
        push(3'd3, 16'd1);
        push(3'd1, 16'd3);
        push(3'd2, 16'd3);
        n = 0;
        while (!(bus.busy === 1'b1 && bus.turn === 3'd0) && n < 100) begin
            step();
            n++;
        end
        chk("dead_seen", bus.busy, 1);
        chk("dead_queued", bus.fifo_count, 2);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_turn",  bus.turn, 0);
        chk("mid_rst_busy",  bus.busy, 0);
        chk("mid_rst_done",  bus.done, 0);
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_err",   bus.err, 0);
        @(negedge clk_50);
        reset = 1'b0;
        exp_err = 1'b0;
        repeat (10) step();
        chk("post_rst_busy",  bus.busy, 0);
        chk("post_rst_count", bus.fifo_count, 0);
        chk("post_rst_turn",  bus.turn, 0);

        // Opposing turns then same-direction hand-over, then random rounds.
        run_round(1'b1);
        for (int r = 0; r < 8; r++) run_round(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
